// File: rtl/mips_mem_pkg.sv
// Shared types for the fetch/data memory port arbiter.
package mips_mem_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } arb_state_t;

  typedef enum logic {
    REQ_FETCH = 1'b0,
    REQ_DATA  = 1'b1
  } req_id_t;

  localparam logic [31:0] BAD_DATA = 32'hDEADBEEF;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner select between fetch and data requests.
// Define ARB_RR_EN to break ties against the previous winner; otherwise data always wins ties.
module mem_arb_pick
  import mips_mem_pkg::*;
(
  input  logic    if_req,
  input  logic    d_req,
  input  req_id_t last,
  output logic    grant_valid,
  output req_id_t grant
);

  assign grant_valid = if_req | d_req;

`ifdef ARB_RR_EN
  always_comb begin
    grant = REQ_DATA;
    if (if_req && d_req) begin
      grant = (last == REQ_DATA) ? REQ_FETCH : REQ_DATA;
    end else if (if_req) begin
      grant = REQ_FETCH;
    end
  end
`else
  logic unused_last;
  assign unused_last = (last == REQ_DATA);

  // Data is the older instruction in the pipeline, so it wins any tie.
  always_comb begin
    grant = REQ_DATA;
    if (if_req && !d_req) begin
      grant = REQ_FETCH;
    end
  end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one variable-latency memory port between fetch and load/store, with access timeout.
// Optional ARB_RR_EN macro enables round-robin tie breaking via a last-winner register.
module mem_port_arbiter
  import mips_mem_pkg::*;
#(
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_done,
  output logic [DW-1:0] if_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic          d_byte,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_done,
  output logic [DW-1:0] d_rdata,
  output logic          mem_req,
  output logic          mem_we,
  output logic          mem_byte,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack,
  output logic          mem_err,
  output logic          stallF,
  output logic          stallM,
  output arb_state_t    state
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] cnt;
  logic          grant_valid;
  req_id_t       grant_id;
  req_id_t       last_win;
  logic          serving;
  logic          finish;
  logic          timed_out;
  logic [DW-1:0] done_data;

`ifdef ARB_RR_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      last_win <= REQ_FETCH;
    end else if (state == IDLE && grant_valid) begin
      last_win <= grant_id;
    end
  end
`else
  assign last_win = REQ_FETCH;
`endif

  mem_arb_pick u_pick (
    .if_req      (if_req),
    .d_req       (d_req),
    .last        (last_win),
    .grant_valid (grant_valid),
    .grant       (grant_id)
  );

  // A reset cycle abandons the access silently, so completion is masked by reset.
  assign serving   = (state != IDLE) && !reset;
  assign finish    = serving && (mem_ack || cnt == CNT_LAST);
  assign timed_out = serving && !mem_ack && (cnt == CNT_LAST);
  assign done_data = mem_ack ? mem_rdata : DW'(BAD_DATA);

  assign if_done  = finish && (state == SERVE_I);
  assign d_done   = finish && (state == SERVE_D);
  assign if_rdata = if_done ? done_data : '0;
  assign d_rdata  = d_done ? done_data : '0;
  assign stallF   = if_req & ~if_done;
  assign stallM   = d_req & ~d_done;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_byte  <= 1'b0;
      mem_err   <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cnt       <= '0;
    end else begin
      mem_err <= timed_out;
      case (state)
        IDLE: begin
          if (grant_valid) begin
            cnt     <= '0;
            mem_req <= 1'b1;
            if (grant_id == REQ_DATA) begin
              state     <= SERVE_D;
              mem_we    <= d_we;
              mem_byte  <= d_we & d_byte;
              mem_addr  <= d_addr;
              mem_wdata <= d_wdata;
            end else begin
              state     <= SERVE_I;
              mem_we    <= 1'b0;
              mem_byte  <= 1'b0;
              mem_addr  <= if_addr;
              mem_wdata <= '0;
            end
          end
        end
        SERVE_I, SERVE_D: begin
          if (finish) begin
            state   <= IDLE;
            mem_req <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus randomized traffic against a
// transaction-level arbitration and memory model.
module tb_mem_port_arbiter;
  import mips_mem_pkg::*;

`ifdef ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_done;
  logic [31:0] if_rdata;
  logic        d_req, d_we, d_byte;
  logic [31:0] d_addr, d_wdata;
  logic        d_done;
  logic [31:0] d_rdata;
  logic        mem_req, mem_we, mem_byte;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ack, mem_err, stallF, stallM;
  arb_state_t  state;

  always #5 clk = ~clk;

  mem_port_arbiter #(.AW(32), .DW(32), .TIMEOUT_CYC(64)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_byte(d_byte), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_done(d_done), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_byte(mem_byte), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .mem_err(mem_err),
    .stallF(stallF), .stallM(stallM), .state(state)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Memory seen by the DUT, and the reference memory the model expects.
  logic [31:0] mem_store [16];
  logic [31:0] ref_mem   [16];
  req_id_t     model_last;

  // Observations of one access, filled by serve().
  logic        s_if, s_d, s_timeout, s_we, s_byte;
  logic [31:0] s_rdata, s_addr, s_wdata;
  int          s_cycles, s_bad;

  function automatic logic pick_data(input logic ifr, input logic dr);
    return dr && (!ifr || !RR || model_last == REQ_FETCH);
  endfunction

  // Acts as the memory: acks on the lat-th cycle of mem_req (lat=0 never acks).
  // Returns at posedge+1 of the cycle after done, so the caller can change requests.
  task automatic serve(input int lat);
    int n = 0;
    s_if = 0; s_d = 0; s_timeout = 1; s_bad = 0; s_cycles = 0;
    s_rdata = '0; s_addr = '0; s_wdata = '0; s_we = 0; s_byte = 0;
    for (int c = 0; c < 200; c++) begin
      @(posedge clk); #1;
      mem_ack = 1'b0;
      mem_rdata = $urandom;
      if (mem_req) begin
        n++;
        if (n == 1) begin
          s_addr = mem_addr; s_we = mem_we; s_byte = mem_byte; s_wdata = mem_wdata;
        end
        if (n == lat) begin
          mem_ack = 1'b1;
          if (mem_we) begin
            if (mem_byte) mem_store[mem_addr[5:2]][7:0] = mem_wdata[7:0];
            else          mem_store[mem_addr[5:2]] = mem_wdata;
          end else begin
            mem_rdata = mem_store[mem_addr[5:2]];
          end
        end
      end
      @(negedge clk);
      if ((if_done && d_done) || mem_err !== 1'b0 ||
          stallF !== (if_req && !if_done) || stallM !== (d_req && !d_done) ||
          (!if_done && if_rdata !== '0) || (!d_done && d_rdata !== '0)) s_bad++;
      if (if_done || d_done) begin
        s_if = if_done; s_d = d_done; s_rdata = if_done ? if_rdata : d_rdata;
        s_cycles = n; s_timeout = 0;
        break;
      end
    end
    @(posedge clk); #1;
    mem_ack = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1; if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_byte = 0;
    d_addr = 0; d_wdata = 0; mem_ack = 0; mem_rdata = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++; if (state !== IDLE) $display("FAIL reset_state: got %0d want %0d", state, IDLE); else n_pass++;
    n_checks++; if ({mem_req, mem_we, mem_byte, mem_err} !== 4'b0) $display("FAIL reset_ctrl: got %b want 0000", {mem_req, mem_we, mem_byte, mem_err}); else n_pass++;
    n_checks++; if ({mem_addr, mem_wdata} !== 64'h0) $display("FAIL reset_addr_data: got %h want 0", {mem_addr, mem_wdata}); else n_pass++;
    @(posedge clk); #1;
    reset = 0;
    model_last = REQ_FETCH;
    @(negedge clk);
    n_checks++; if ({if_done, d_done, stallF, stallM} !== 4'b0) $display("FAIL reset_outputs: got %b want 0000", {if_done, d_done, stallF, stallM}); else n_pass++;
  endtask

  task automatic test_fetch_only();
    mem_store[0] = 32'h20020005; ref_mem[0] = 32'h20020005;
    @(posedge clk); #1;
    if_req = 1; if_addr = 32'h0;
    @(negedge clk);
    n_checks++; if (stallF !== 1'b1) $display("FAIL fetch_stall_pending: got %b want 1", stallF); else n_pass++;
    serve(3);
    n_checks++; if ({s_timeout, s_if, s_d} !== 3'b010) $display("FAIL fetch_done: got to/if/d %b want 010", {s_timeout, s_if, s_d}); else n_pass++;
    n_checks++; if (s_rdata !== 32'h20020005) $display("FAIL fetch_rdata: got %h want 20020005", s_rdata); else n_pass++;
    n_checks++; if (s_cycles !== 3) $display("FAIL fetch_req_cycles: got %0d want 3", s_cycles); else n_pass++;
    n_checks++; if ({s_addr, s_we} !== 33'h0) $display("FAIL fetch_mem_fields: got addr %h we %b want 0/0", s_addr, s_we); else n_pass++;
    n_checks++; if (s_bad !== 0) $display("FAIL fetch_protocol: got %0d bad cycles want 0", s_bad); else n_pass++;
    if_req = 0;
    model_last = REQ_FETCH;
    @(negedge clk);
    n_checks++; if ({mem_req, stallF, if_done} !== 3'b0) $display("FAIL fetch_after: got req/stall/done %b want 000", {mem_req, stallF, if_done}); else n_pass++;
  endtask

  task automatic test_store();
    @(posedge clk); #1;
    d_req = 1; d_we = 1; d_byte = 0; d_addr = 32'd12; d_wdata = 32'h3F;
    ref_mem[3] = 32'h3F;
    serve(2);
    n_checks++; if ({s_timeout, s_if, s_d} !== 3'b001) $display("FAIL store_done: got to/if/d %b want 001", {s_timeout, s_if, s_d}); else n_pass++;
    n_checks++; if (s_addr !== 32'd12 || s_we !== 1'b1 || s_byte !== 1'b0 || s_wdata !== 32'h3F)
      $display("FAIL store_mem_fields: got addr %h we %b byte %b wdata %h want c/1/0/3f", s_addr, s_we, s_byte, s_wdata); else n_pass++;
    n_checks++; if (s_cycles !== 2) $display("FAIL store_req_cycles: got %0d want 2", s_cycles); else n_pass++;
    d_req = 0; d_we = 0;
    model_last = REQ_DATA;
    @(negedge clk);
    n_checks++; if ({mem_req, stallM} !== 2'b0) $display("FAIL store_after: got req/stallM %b want 00", {mem_req, stallM}); else n_pass++;
    n_checks++; if (mem_store[3] !== 32'h3F) $display("FAIL store_written: got %h want 3f", mem_store[3]); else n_pass++;
  endtask

  task automatic test_tie();
    logic exp_d;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      if_req = 1; if_addr = 32'd24; d_req = 1; d_we = 0; d_byte = 0; d_addr = 32'd20;
      exp_d = pick_data(1'b1, 1'b1);
      serve(1 + $urandom_range(0, 3));
      n_checks++; if (s_d !== exp_d || s_if !== !exp_d) $display("FAIL tie_first_winner: got if/d %b%b want d=%b", s_if, s_d, exp_d); else n_pass++;
      n_checks++; if (s_rdata !== (exp_d ? ref_mem[5] : ref_mem[6])) $display("FAIL tie_first_rdata: got %h want %h", s_rdata, exp_d ? ref_mem[5] : ref_mem[6]); else n_pass++;
      model_last = exp_d ? REQ_DATA : REQ_FETCH;
      if (exp_d) d_req = 0; else if_req = 0;
      serve(1 + $urandom_range(0, 3));
      n_checks++; if (s_d !== !exp_d || s_if !== exp_d) $display("FAIL tie_second_winner: got if/d %b%b want d=%b", s_if, s_d, !exp_d); else n_pass++;
      n_checks++; if (s_rdata !== (exp_d ? ref_mem[6] : ref_mem[5])) $display("FAIL tie_second_rdata: got %h want %h", s_rdata, exp_d ? ref_mem[6] : ref_mem[5]); else n_pass++;
      model_last = exp_d ? REQ_FETCH : REQ_DATA;
      if_req = 0; d_req = 0;
      @(negedge clk);
    end
  endtask

  task automatic test_byte();
    logic [31:0] wd;
    wd = $urandom;
    @(posedge clk); #1;
    d_req = 1; d_we = 1; d_byte = 1; d_addr = 32'd8; d_wdata = wd;
    ref_mem[2][7:0] = wd[7:0];
    serve(2);
    n_checks++; if (s_d !== 1'b1 || s_we !== 1'b1 || s_byte !== 1'b1) $display("FAIL byte_store: got d/we/byte %b%b%b want 111", s_d, s_we, s_byte); else n_pass++;
    model_last = REQ_DATA;
    d_req = 0;
    if_req = 1; if_addr = 32'd8;
    serve(1);
    n_checks++; if (s_if !== 1'b1 || s_we !== 1'b0 || s_byte !== 1'b0) $display("FAIL byte_fetch_masked: got if/we/byte %b%b%b want 100", s_if, s_we, s_byte); else n_pass++;
    n_checks++; if (s_rdata !== ref_mem[2]) $display("FAIL byte_merge: got %h want %h", s_rdata, ref_mem[2]); else n_pass++;
    model_last = REQ_FETCH;
    if_req = 0; d_we = 0; d_byte = 0;
    @(negedge clk);
  endtask

  task automatic test_timeout();
    @(posedge clk); #1;
    d_req = 1; d_we = 0; d_addr = 32'd4;
    serve(0);
    n_checks++; if ({s_timeout, s_d} !== 2'b01) $display("FAIL timeout_done: got to/d %b want 01", {s_timeout, s_d}); else n_pass++;
    n_checks++; if (s_rdata !== 32'hDEADBEEF) $display("FAIL timeout_rdata: got %h want deadbeef", s_rdata); else n_pass++;
    n_checks++; if (s_cycles !== 64) $display("FAIL timeout_cycles: got %0d want 64", s_cycles); else n_pass++;
    n_checks++; if (s_bad !== 0) $display("FAIL timeout_protocol: got %0d bad cycles want 0", s_bad); else n_pass++;
    d_req = 0;
    model_last = REQ_DATA;
    @(negedge clk);
    n_checks++; if ({mem_err, mem_req} !== 2'b10 || state !== IDLE) $display("FAIL timeout_err_pulse: got err/req %b state %0d want 10/IDLE", {mem_err, mem_req}, state); else n_pass++;
    @(negedge clk);
    n_checks++; if (mem_err !== 1'b0) $display("FAIL timeout_err_single: got %b want 0", mem_err); else n_pass++;
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    d_req = 1; d_we = 1; d_byte = 0; d_addr = 32'd16; d_wdata = $urandom;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++; if (mem_req !== 1'b1 || state !== SERVE_D) $display("FAIL reset_mid_busy: got req %b state %0d want 1/SERVE_D", mem_req, state); else n_pass++;
    @(posedge clk); #1;
    reset = 1; mem_ack = 1;
    @(negedge clk);
    n_checks++; if ({d_done, if_done} !== 2'b0) $display("FAIL reset_mid_no_done: got %b want 00", {d_done, if_done}); else n_pass++;
    @(posedge clk); #1;
    reset = 0; d_req = 0; d_we = 0; mem_ack = 1;
    model_last = REQ_FETCH;
    @(negedge clk);
    n_checks++; if ({mem_req, d_done, if_done, mem_err} !== 4'b0 || state !== IDLE) $display("FAIL reset_mid_late_ack: got req/d/if/err %b state %0d want 0000/IDLE", {mem_req, d_done, if_done, mem_err}, state); else n_pass++;
    @(posedge clk); #1;
    mem_ack = 0;
    @(negedge clk);
  endtask

  task automatic test_random();
    logic        if_p, d_p, exp_d, r_we, r_byte;
    logic [31:0] r_iaddr, r_daddr, r_wdata, exp_addr, exp_rd;
    int          lat;
    if_p = 0; d_p = 0;
    @(posedge clk); #1;
    for (int it = 0; it < 40; it++) begin
      if (!if_p && $urandom_range(0, 1) == 1) begin
        if_p = 1; r_iaddr = {26'h0, 4'($urandom_range(0, 15)), 2'b00};
      end
      if (!d_p && $urandom_range(0, 1) == 1) begin
        d_p = 1; r_we = 1'($urandom_range(0, 1)); r_byte = 1'($urandom_range(0, 1));
        r_daddr = {26'h0, 4'($urandom_range(0, 15)), 2'b00}; r_wdata = $urandom;
      end
      if (!if_p && !d_p) begin
        if_p = 1; r_iaddr = {26'h0, 4'($urandom_range(0, 15)), 2'b00};
      end
      if_req = if_p; if_addr = r_iaddr;
      d_req = d_p; d_we = r_we; d_byte = r_byte; d_addr = r_daddr; d_wdata = r_wdata;
      exp_d = pick_data(if_p, d_p);
      exp_addr = exp_d ? r_daddr : r_iaddr;
      exp_rd = ref_mem[exp_addr[5:2]];
      if (exp_d && r_we) begin
        if (r_byte) ref_mem[r_daddr[5:2]][7:0] = r_wdata[7:0];
        else        ref_mem[r_daddr[5:2]] = r_wdata;
      end
      lat = $urandom_range(1, 4);
      serve(lat);
      n_checks++; if (s_d !== exp_d || s_if !== !exp_d || s_cycles !== lat) $display("FAIL rand_grant it%0d: got if/d %b%b cycles %0d want d=%b cycles %0d", it, s_if, s_d, s_cycles, exp_d, lat); else n_pass++;
      n_checks++; if (s_addr !== exp_addr || s_we !== (exp_d && r_we)) $display("FAIL rand_mem_fields it%0d: got addr %h we %b want %h/%b", it, s_addr, s_we, exp_addr, exp_d && r_we); else n_pass++;
      if (exp_d && r_we) begin
        n_checks++; if (s_byte !== r_byte || s_wdata !== r_wdata) $display("FAIL rand_store it%0d: got byte %b wdata %h want %b/%h", it, s_byte, s_wdata, r_byte, r_wdata); else n_pass++;
      end else begin
        n_checks++; if (s_rdata !== exp_rd) $display("FAIL rand_rdata it%0d: got %h want %h", it, s_rdata, exp_rd); else n_pass++;
      end
      n_checks++; if (s_bad !== 0) $display("FAIL rand_protocol it%0d: got %0d bad cycles want 0", it, s_bad); else n_pass++;
      model_last = exp_d ? REQ_DATA : REQ_FETCH;
      if (exp_d) d_p = 0; else if_p = 0;
    end
    if_req = 0; d_req = 0;
    @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      n_checks++; if (mem_store[i] !== ref_mem[i]) $display("FAIL rand_mem_word%0d: got %h want %h", i, mem_store[i], ref_mem[i]); else n_pass++;
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      mem_store[i] = $urandom;
      ref_mem[i] = mem_store[i];
    end
    test_reset();
    test_fetch_only();
    test_store();
    test_tie();
    test_byte();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
